zmod_adc_relay_sequencer: RTL



---
 rtl/zmod_relay_pkg.sv | 29 ++
 rtl/zmod_relay_timer.sv | 30 +++
 rtl/zmod_adc_relay_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/zmod_relay_pkg.sv
// Shared types and constants for the ZmodScope relay sequencer.
// Relay indices double as bit positions in cfg_tdata and relay_state.
package zmod_relay_pkg;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_LOAD,
      ST_PULSE,
      ST_GAP,
      ST_SETTLE,
      ST_IDLE
   } relaySeqState_e;

   localparam logic [1:0] RLY_CPL_A  = 2'd0;
   localparam logic [1:0] RLY_CPL_B  = 2'd1;
   localparam logic [1:0] RLY_GAIN_A = 2'd2;
   localparam logic [1:0] RLY_GAIN_B = 2'd3;

   // Lowest set bit wins so that relays are serviced in ascending order.
   function automatic logic [1:0] lowestSet(input logic [3:0] m);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/zmod_relay_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module zmod_relay_timer #(
   parameter int CNT_WIDTH = 20
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 load_i,
   input  logic [CNT_WIDTH-1:0] loadVal_i,
   output logic                 done_o
);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = loadVal_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/zmod_adc_relay_sequencer.sv
// Pulses the ZmodScope latching relay coils one at a time and blanks ADC data meanwhile.
// Define ZMOD_RELAY_SKIP_UNCHANGED_EN to pulse only relays whose position actually changes.
import zmod_relay_pkg::*;

module zmod_adc_relay_sequencer #(
   parameter int unsigned PULSE_CYCLES  = 1000000,
   parameter int unsigned GAP_CYCLES    = 100000,
   parameter int unsigned SETTLE_CYCLES = 200000,
   parameter int          CNT_WIDTH     = 20,
   parameter logic [3:0]  DEF_CFG       = 4'b1100
) (
   input  logic       aclk,
   input  logic       reset,
   input  logic [3:0] cfg_tdata,
   input  logic       cfg_tvalid,
   output logic       cfg_tready,
   output logic       busy,
   output logic       adc_blank,
   output logic [3:0] relay_state,
   output logic       coupling_h_a,
   output logic       coupling_l_a,
   output logic       coupling_h_b,
   output logic       coupling_l_b,
   output logic       gain_h_a,
   output logic       gain_l_a,
   output logic       gain_h_b,
   output logic       gain_l_b,
   output logic       com_h,
   output logic       com_l
);

   localparam logic [CNT_WIDTH-1:0] PULSE_LD  = CNT_WIDTH'(PULSE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] GAP_LD    = CNT_WIDTH'(GAP_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] SETTLE_LD = CNT_WIDTH'(SETTLE_CYCLES - 1);

   relaySeqState_e       state_q, state_d;
   logic [3:0]           target_q, mask_q, relayState_q, loadMask;
   logic [1:0]           idx_q;
   logic                 timerLoad, timerDone, pulseBit;
   logic [CNT_WIDTH-1:0] timerVal;

   zmod_relay_timer #(.CNT_WIDTH(CNT_WIDTH)) uTimer (
      .clk_i     (aclk),
      .reset_i   (reset),
      .load_i    (timerLoad),
      .loadVal_i (timerVal),
      .done_o    (timerDone)
   );

`ifdef ZMOD_RELAY_SKIP_UNCHANGED_EN
   // The power-on sequence must resync every relay regardless of the shadow state.
   logic forceAll_q;
   assign loadMask = forceAll_q ? 4'b1111 : (target_q ^ relayState_q);
`else
   assign loadMask = 4'b1111;
`endif

   assign pulseBit    = target_q[idx_q];
   assign relay_state = relayState_q;

   always_ff @(posedge aclk) begin
      if (reset) state_q <= ST_INIT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      timerLoad = 1'b0;
      timerVal  = '0;
      case (state_q)
         ST_INIT: state_d = ST_LOAD;
         ST_LOAD: begin
            if (loadMask == 4'b0000) begin
               state_d = ST_IDLE;
            end else begin
               state_d   = ST_PULSE;
               timerLoad = 1'b1;
               timerVal  = PULSE_LD;
            end
         end
         ST_PULSE: begin
            if (timerDone) begin
               state_d   = ST_GAP;
               timerLoad = 1'b1;
               timerVal  = GAP_LD;
            end
         end
         ST_GAP: begin
            if (timerDone) begin
               timerLoad = 1'b1;
               if (mask_q != 4'b0000) begin
                  state_d  = ST_PULSE;
                  timerVal = PULSE_LD;
               end else begin
                  state_d  = ST_SETTLE;
                  timerVal = SETTLE_LD;
               end
            end
         end
         ST_SETTLE: if (timerDone) state_d = ST_IDLE;
         ST_IDLE:   if (cfg_tvalid) state_d = ST_LOAD;
         default:   state_d = ST_INIT;
      endcase
   end

   // Serviced relays drop out of the mask on their last pulse cycle, so GAP only asks "anything left".
   always_ff @(posedge aclk) begin
      if (reset) begin
         target_q     <= DEF_CFG;
         mask_q       <= 4'b1111;
         idx_q        <= 2'd0;
         relayState_q <= DEF_CFG;
`ifdef ZMOD_RELAY_SKIP_UNCHANGED_EN
         forceAll_q   <= 1'b1;
`endif
      end else begin
         case (state_q)
            ST_INIT: begin
               target_q   <= DEF_CFG;
               mask_q     <= 4'b1111;
`ifdef ZMOD_RELAY_SKIP_UNCHANGED_EN
               forceAll_q <= 1'b1;
`endif
            end
            ST_LOAD: begin
               mask_q <= loadMask;
               idx_q  <= lowestSet(loadMask);
            end
            ST_PULSE: begin
               if (timerDone) begin
                  relayState_q[idx_q] <= pulseBit;
                  mask_q[idx_q]       <= 1'b0;
               end
            end
            ST_GAP: if (timerDone) idx_q <= lowestSet(mask_q);
            ST_IDLE: begin
               if (cfg_tvalid) begin
                  target_q   <= cfg_tdata;
`ifdef ZMOD_RELAY_SKIP_UNCHANGED_EN
                  forceAll_q <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   // Only the selected coil pair and the common return are ever energised, and only in PULSE.
   always_comb begin
      cfg_tready   = (state_q == ST_IDLE);
      busy         = (state_q != ST_IDLE);
      adc_blank    = (state_q != ST_IDLE);
      coupling_h_a = 1'b0;
      coupling_l_a = 1'b0;
      coupling_h_b = 1'b0;
      coupling_l_b = 1'b0;
      gain_h_a     = 1'b0;
      gain_l_a     = 1'b0;
      gain_h_b     = 1'b0;
      gain_l_b     = 1'b0;
      com_h        = 1'b0;
      com_l        = 1'b0;
      if (state_q == ST_PULSE) begin
         com_h = ~pulseBit;
         com_l = pulseBit;
         case (idx_q)
            RLY_CPL_A:  begin coupling_h_a = pulseBit; coupling_l_a = ~pulseBit; end
            RLY_CPL_B:  begin coupling_h_b = pulseBit; coupling_l_b = ~pulseBit; end
            RLY_GAIN_A: begin gain_h_a     = pulseBit; gain_l_a     = ~pulseBit; end
            RLY_GAIN_B: begin gain_h_b     = pulseBit; gain_l_b     = ~pulseBit; end
            default: ;
         endcase
      end
   end

endmodule
